stl_pipe_fifo: RTL and testbench
================================

// Module: stl_pipe_fifo
// PURPOSE
//   Parametrised valid/ready buffer: DEPTH-entry elastic stage with fully registered
//   ready, valid and data (no combinational path from any input to any output).
//   Drops in between producer/consumer blocks where a 2-entry skid stage is not enough
//   to absorb burst back-pressure. Adds occupancy, almost-full and synchronous flush.
// PARAMETERS
//   DATA_W   10  payload width in bits (>=1)
//   DEPTH     4  number of entries (>=2, need not be a power of 2)
//   AFULL_TH  3  afull_o asserts when occupancy >= AFULL_TH (1..DEPTH)
//   CNT_W    $clog2(DEPTH+1)  occupancy width (derived, do not override)
// PORTS
//   clk      in   1       clock, all state on rising edge
//   rst      in   1       asynchronous, active-high reset
//   flush_i  in   1       synchronous flush, drops all stored entries
//   upvld_i  in   1       upstream valid
//   uprdy_o  out  1       upstream ready (registered)
//   updat_i  in   DATA_W  upstream payload
//   dnvld_o  out  1       downstream valid (registered)
//   dnrdy_i  in   1       downstream ready
//   dndat_o  out  DATA_W  downstream payload (head entry, from storage registers)
//   count_o  out  CNT_W   current occupancy 0..DEPTH (registered)
//   afull_o  out  1       occupancy >= AFULL_TH (registered)
// BEHAVIOUR
//   - Reset (async, rst=1): uprdy_o=1, dnvld_o=0, count_o=0, afull_o=0, wr/rd ptr=0.
//     dndat_o and storage are not reset; dndat_o is don't-care while dnvld_o=0.
//   - push = upvld_i & uprdy_o; pop = dnvld_o & dnrdy_i. Payload never changes
//     while dnvld_o=1 and dnrdy_i=0; updat_i only sampled on push.
//   - uprdy_o = (count_next < DEPTH), registered; dnvld_o = (count_next != 0), registered.
//     count_next = count_o + push - pop (push and pop may both occur in one cycle).
//   - Latency: push into empty buffer -> dnvld_o=1 with that payload next cycle.
//   - Full (count_o=DEPTH): uprdy_o=0 even if dnrdy_i=1 this cycle; after a pop,
//     uprdy_o returns to 1 the following cycle (one-cycle ready bubble, by design).
//   - Empty: dnvld_o=0; dnrdy_i ignored; no pop, pointers unchanged.
//   - Simultaneous push+pop at 0<count<DEPTH: count unchanged, both pointers advance.
//   - Pointers wrap DEPTH-1 -> 0 (explicit compare, not binary overflow).
//   - Strict FIFO order; no entry duplicated or lost except by flush.
//   - flush_i=1: next cycle count_o=0, dnvld_o=0, uprdy_o=1, afull_o=0, ptrs=0.
//     Any push or pop in the flush cycle is discarded (handshake on ports still
//     looks completed to the neighbours; owners of flush_i accept that loss).
//   - afull_o = (count_next >= AFULL_TH), registered, updates in lockstep with count_o.
//   - rst asserted mid-transfer: all state clears immediately (async); contents lost.
//   - Reset release: uprdy_o=1 from first cycle; first push may occur in that cycle.
// TESTING
//   1 DEPTH=4: push A,B,C,D back-to-back, dnrdy_i=0 -> uprdy_o=0 after D, count_o=4,
//     afull_o=1 after C; then dnrdy_i=1 -> pops A,B,C,D in order, dnvld_o=0 after D.
//   2 Streaming: upvld_i=1, dnrdy_i=1 every cycle, payload 0..99 -> output 0..99 in
//     order, 1 cycle latency, count_o holds 1, no uprdy_o deassertion.
//   3 Full + dnrdy_i=1 same cycle with upvld_i=1 -> push refused that cycle, pop
//     accepted; next cycle uprdy_o=1, count_o=3; refused word re-offered and stored.
//   4 Wrap: random upvld_i/dnrdy_i (50%) for 1000 cycles, DEPTH=3 and DEPTH=5 ->
//     scoreboard order exact, count_o always equals model, never > DEPTH.
//   5 Flush with count_o=3 and push+pop asserted -> next cycle count_o=0, dnvld_o=0,
//     uprdy_o=1; next pushed word E is the first word popped.
//   6 Assert rst mid-burst at count_o=2 -> outputs at reset values same cycle
//     (before next edge); after release, a single push appears 1 cycle later.

Source files
------------

// File: rtl/stl_pipe_fifo.sv
// stl_pipe_fifo: DEPTH-entry valid/ready elastic buffer.
// Ready, valid, occupancy and almost-full all come straight from flops.
// The payload is read from storage at the registered read pointer, so no
// input reaches any output combinationally. Also provides a synchronous flush.
module stl_pipe_fifo #(
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AFULL_TH = 3,
    parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              upvld_i,
    output logic              uprdy_o,
    input  logic [DATA_W-1:0] updat_i,
    output logic              dnvld_o,
    input  logic              dnrdy_i,
    output logic [DATA_W-1:0] dndat_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              afull_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              uprdy_q, uprdy_d;
    logic              dnvld_q, dnvld_d;
    logic              afull_q, afull_d;
    logic              push, pop;

    // Handshakes use only the registered flags on our side of each interface.
    assign push = upvld_i & uprdy_q;
    assign pop  = dnvld_q & dnrdy_i;

    // DEPTH need not be a power of two, so wrap by compare rather than overflow.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state: pointers, occupancy and the flags derived from next occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            // Handshakes in the flush cycle are dropped on purpose.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        uprdy_d = (count_d < CNT_W'(DEPTH));
        dnvld_d = (count_d != '0);
        afull_d = (count_d >= CNT_W'(AFULL_TH));
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            uprdy_q  <= 1'b1;
            dnvld_q  <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            uprdy_q  <= uprdy_d;
            dnvld_q  <= dnvld_d;
            afull_q  <= afull_d;
        end
    end

    // Payload storage; not reset since contents are only read while valid.
    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            mem[wr_ptr_q] <= updat_i;
        end
    end

    assign uprdy_o = uprdy_q;
    assign dnvld_o = dnvld_q;
    assign dndat_o = mem[rd_ptr_q];
    assign count_o = count_q;
    assign afull_o = afull_q;

endmodule

// File: tb/tb_stl_pipe_fifo.sv
// Bench for stl_pipe_fifo: three instances (DEPTH 4, 3, 5) share one stimulus
// stream and each is tracked by a queue-based reference model. Directed
// vectors and sequences target the DEPTH=4 instance.
module tb_stl_pipe_fifo;

    localparam int unsigned DW = 10;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          upvld;
    logic [DW-1:0] updat;
    logic          dnrdy;

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned D  = (g == 0) ? 4 : ((g == 1) ? 3 : 5);
        localparam int unsigned TH = (g == 0) ? 3 : ((g == 1) ? 2 : 4);
        localparam int unsigned CW = $clog2(D + 1);

        logic          uprdy;
        logic          dnvld;
        logic          afull;
        logic [DW-1:0] dndat;
        logic [CW-1:0] count;

        stl_pipe_fifo #(
            .DATA_W   (DW),
            .DEPTH    (D),
            .AFULL_TH (TH)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush),
            .upvld_i (upvld),
            .uprdy_o (uprdy),
            .updat_i (updat),
            .dnvld_o (dnvld),
            .dnrdy_i (dnrdy),
            .dndat_o (dndat),
            .count_o (count),
            .afull_o (afull)
        );

        // Reference: a plain queue; ready means room, valid means non-empty.
        logic [DW-1:0] q[$];
        int            exp_cnt;
        logic          exp_vld;
        logic          exp_rdy;
        logic          exp_af;
        logic [DW-1:0] exp_dat;

        always @(posedge clk or posedge rst) begin : model
            bit pu;
            bit po;
            if (rst || flush) begin
                q.delete();
            end else begin
                pu = upvld && (q.size() < D);
                po = dnrdy && (q.size() > 0);
                if (po) void'(q.pop_front());
                if (pu) q.push_back(updat);
            end
            exp_cnt = q.size();
            exp_vld = (q.size() > 0);
            exp_rdy = (q.size() < D);
            exp_af  = (q.size() >= TH);
            exp_dat = (q.size() > 0) ? q[0] : '0;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_models();
        cmp("d4 count", 32'(g_dut[0].count), g_dut[0].exp_cnt);
        cmp("d4 uprdy", 32'(g_dut[0].uprdy), 32'(g_dut[0].exp_rdy));
        cmp("d4 dnvld", 32'(g_dut[0].dnvld), 32'(g_dut[0].exp_vld));
        cmp("d4 afull", 32'(g_dut[0].afull), 32'(g_dut[0].exp_af));
        if (g_dut[0].exp_vld) cmp("d4 dndat", 32'(g_dut[0].dndat), 32'(g_dut[0].exp_dat));
        cmp("d3 count", 32'(g_dut[1].count), g_dut[1].exp_cnt);
        cmp("d3 uprdy", 32'(g_dut[1].uprdy), 32'(g_dut[1].exp_rdy));
        cmp("d3 dnvld", 32'(g_dut[1].dnvld), 32'(g_dut[1].exp_vld));
        cmp("d3 afull", 32'(g_dut[1].afull), 32'(g_dut[1].exp_af));
        if (g_dut[1].exp_vld) cmp("d3 dndat", 32'(g_dut[1].dndat), 32'(g_dut[1].exp_dat));
        cmp("d5 count", 32'(g_dut[2].count), g_dut[2].exp_cnt);
        cmp("d5 uprdy", 32'(g_dut[2].uprdy), 32'(g_dut[2].exp_rdy));
        cmp("d5 dnvld", 32'(g_dut[2].dnvld), 32'(g_dut[2].exp_vld));
        cmp("d5 afull", 32'(g_dut[2].afull), 32'(g_dut[2].exp_af));
        if (g_dut[2].exp_vld) cmp("d5 dndat", 32'(g_dut[2].dndat), 32'(g_dut[2].exp_dat));
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        check_models();
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        upvld = v;
        updat = d;
        dnrdy = r;
        flush = f;
    endtask

    typedef struct {
        logic          vld;
        logic [DW-1:0] dat;
        logic          rdy;
        logic          fl;
        int            cnt;
        logic          ur;
        logic          dv;
        logic          af;
        logic [DW-1:0] ddat;
    } vec_t;

    vec_t tv[$];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);

        // {vld, dat, rdy, flush, exp count, uprdy, dnvld, afull, dndat}
        // Fill to full with no drain, extra word refused, then drain in order.
        tv.push_back('{1'b1, 10'h1A1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 10'h1A1});
        tv.push_back('{1'b1, 10'h1B2, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 10'h1A1});
        tv.push_back('{1'b1, 10'h1C3, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b1, 10'h1A1});
        tv.push_back('{1'b1, 10'h2D4, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1, 10'h1A1});
        tv.push_back('{1'b1, 10'h3FF, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1, 10'h1A1});
        tv.push_back('{1'b0, 10'h000, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b1, 10'h1B2});
        tv.push_back('{1'b0, 10'h000, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 10'h1C3});
        tv.push_back('{1'b0, 10'h000, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 10'h2D4});
        tv.push_back('{1'b0, 10'h000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 10'h000});
        tv.push_back('{1'b0, 10'h000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 10'h000});
        // Full with push and pop offered together: push refused, then re-offered.
        tv.push_back('{1'b1, 10'h101, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 10'h101});
        tv.push_back('{1'b1, 10'h102, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 10'h101});
        tv.push_back('{1'b1, 10'h103, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b1, 10'h101});
        tv.push_back('{1'b1, 10'h104, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1, 10'h101});
        tv.push_back('{1'b1, 10'h155, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b1, 10'h102});
        tv.push_back('{1'b1, 10'h155, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1, 10'h102});
        tv.push_back('{1'b0, 10'h000, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b1, 10'h103});
        tv.push_back('{1'b0, 10'h000, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 10'h104});
        tv.push_back('{1'b0, 10'h000, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 10'h155});
        tv.push_back('{1'b0, 10'h000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 10'h000});
        // Flush at count 3 with push and pop asserted; E is next word out.
        tv.push_back('{1'b1, 10'h201, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 10'h201});
        tv.push_back('{1'b1, 10'h202, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 10'h201});
        tv.push_back('{1'b1, 10'h203, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b1, 10'h201});
        tv.push_back('{1'b1, 10'h204, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 10'h000});
        tv.push_back('{1'b1, 10'h3EE, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 10'h3EE});
        tv.push_back('{1'b0, 10'h000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 10'h000});

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        cmp("reset uprdy", 32'(g_dut[0].uprdy), 32'd1);
        cmp("reset dnvld", 32'(g_dut[0].dnvld), 32'd0);
        cmp("reset count", 32'(g_dut[0].count), 32'd0);
        cmp("reset afull", 32'(g_dut[0].afull), 32'd0);
        rst = 1'b0;

        // Table vectors; first push lands in the first cycle after release.
        foreach (tv[i]) begin
            drive(tv[i].vld, tv[i].dat, tv[i].rdy, tv[i].fl);
            step();
            cmp($sformatf("vec%0d count", i), 32'(g_dut[0].count), tv[i].cnt);
            cmp($sformatf("vec%0d uprdy", i), 32'(g_dut[0].uprdy), 32'(tv[i].ur));
            cmp($sformatf("vec%0d dnvld", i), 32'(g_dut[0].dnvld), 32'(tv[i].dv));
            cmp($sformatf("vec%0d afull", i), 32'(g_dut[0].afull), 32'(tv[i].af));
            if (tv[i].dv) begin
                cmp($sformatf("vec%0d dndat", i), 32'(g_dut[0].dndat), 32'(tv[i].ddat));
            end
        end

        // Streaming: one word in and out every cycle, one cycle latency.
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, DW'(k), 1'b1, 1'b0);
            step();
            cmp($sformatf("stream%0d dndat", k), 32'(g_dut[0].dndat), k);
            cmp($sformatf("stream%0d count", k), 32'(g_dut[0].count), 32'd1);
            cmp($sformatf("stream%0d uprdy", k), 32'(g_dut[0].uprdy), 32'd1);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        cmp("stream drain count", 32'(g_dut[0].count), 32'd0);

        // Async reset mid-burst at count 2, then a single push after release.
        drive(1'b1, 10'h011, 1'b0, 1'b0);
        step();
        drive(1'b1, 10'h022, 1'b0, 1'b0);
        step();
        cmp("pre-rst count", 32'(g_dut[0].count), 32'd2);
        drive(1'b1, 10'h2AA, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        cmp("async rst uprdy", 32'(g_dut[0].uprdy), 32'd1);
        cmp("async rst dnvld", 32'(g_dut[0].dnvld), 32'd0);
        cmp("async rst count", 32'(g_dut[0].count), 32'd0);
        cmp("async rst afull", 32'(g_dut[0].afull), 32'd0);
        #2;
        rst = 1'b0;
        step();
        cmp("post-rst dnvld", 32'(g_dut[0].dnvld), 32'd1);
        cmp("post-rst dndat", 32'(g_dut[0].dndat), 32'h2AA);
        cmp("post-rst count", 32'(g_dut[0].count), 32'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        cmp("post-rst drain", 32'(g_dut[0].count), 32'd0);

        // Random traffic checked against the queue models for all three depths.
        for (int k = 0; k < 1000; k++) begin
            drive(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 63) == 0));
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
